key_entry_sequencer: RTL and testbench

//   Consumer end of the button_reader key stream: accepts 5-bit key codes over valid/ready.

---
 rtl/key_entry_sequencer_if.sv | 31 +++
 rtl/key_entry_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_key_entry_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_entry_sequencer_if.sv
// Key-stream and ALU request/result bundle for key_entry_sequencer.
// The sequencer consumes keys, issues ALU requests and drives the display,
// so it connects through the slave modport; the environment (key source,
// ALU model, display sink) uses the master modport.
interface key_entry_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [4:0]       i_key;
  logic             i_key_valid;
  logic             o_key_ready;
  logic [WIDTH-1:0] o_alu_a;
  logic [WIDTH-1:0] o_alu_b;
  logic [1:0]       o_alu_op;
  logic             o_alu_valid;
  logic             i_alu_ready;
  logic [WIDTH-1:0] i_res;
  logic             i_res_err;
  logic             i_res_valid;
  logic [WIDTH-1:0] o_display;
  logic             o_error;

  modport slave (
    input  i_key, i_key_valid, i_alu_ready, i_res, i_res_err, i_res_valid,
    output o_key_ready, o_alu_a, o_alu_b, o_alu_op, o_alu_valid, o_display, o_error
  );

  modport master (
    output i_key, i_key_valid, i_alu_ready, i_res, i_res_err, i_res_valid,
    input  o_key_ready, o_alu_a, o_alu_b, o_alu_op, o_alu_valid, o_display, o_error
  );
endinterface

// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer: turns the button_reader key stream into decimal
// operands and ALU requests, tracks operator chaining (e.g. 7*6-2=) and
// feeds the display path with the operand being typed or the last result.
module key_entry_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  key_entry_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_ENTRY_A  = 3'd0,
    ST_OP       = 3'd1,
    ST_ENTRY_B  = 3'd2,
    ST_REQ      = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_RESULT   = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  localparam logic [4:0] KEY_AC  = 5'd16;
  localparam logic [4:0] KEY_ADD = 5'd17;
  localparam logic [4:0] KEY_DIV = 5'd20;
  localparam logic [4:0] KEY_EQ  = 5'd21;

  // Decimal shift-in of one digit, computed 4 bits wider than the operand
  // so an out-of-range result is visible in the top bits instead of wrapping.
  function automatic logic [WIDTH+3:0] acc_digit(input logic [WIDTH-1:0] v,
                                                 input logic [3:0]       d);
    logic [WIDTH+3:0] ten;
    ten = {{WIDTH{1'b0}}, 4'd10};
    return ({4'd0, v} * ten) + {{WIDTH{1'b0}}, d};
  endfunction

  state_t           state_r,   state_s;
  logic [WIDTH-1:0] a_r,       a_s;
  logic [WIDTH-1:0] b_r,       b_s;
  logic [1:0]       op_r,      op_s;
  logic [1:0]       next_op_r, next_op_s;
  logic             chain_r,   chain_s;

  logic             key_ready_s;
  logic             key_fire_s;
  logic             is_digit_s;
  logic             is_arith_s;
  logic             is_eq_s;
  logic             is_ac_s;
  logic [1:0]       key_op_s;
  logic [WIDTH-1:0] digit_s;
  logic [WIDTH+3:0] acc_a_s;
  logic [WIDTH+3:0] acc_b_s;
  logic             acc_a_fits_s;
  logic             acc_b_fits_s;

  // Key decode, handshake and digit-accumulation candidates.
  always_comb begin
    key_ready_s  = (state_r != ST_REQ) && (state_r != ST_WAIT_RES);
    key_fire_s   = bus.i_key_valid & key_ready_s;
    is_digit_s   = (bus.i_key <= 5'd9);
    is_ac_s      = (bus.i_key == KEY_AC);
    is_arith_s   = (bus.i_key >= KEY_ADD) && (bus.i_key <= KEY_DIV);
    is_eq_s      = (bus.i_key == KEY_EQ);
    // ADD(17)..DIV(20) map to 00..11: low two bits minus one, mod 4.
    key_op_s     = bus.i_key[1:0] - 2'd1;
    digit_s      = {{(WIDTH-4){1'b0}}, bus.i_key[3:0]};
    acc_a_s      = acc_digit(a_r, bus.i_key[3:0]);
    acc_b_s      = acc_digit(b_r, bus.i_key[3:0]);
    acc_a_fits_s = (acc_a_s[WIDTH+3:WIDTH] == 4'd0);
    acc_b_fits_s = (acc_b_s[WIDTH+3:WIDTH] == 4'd0);
  end

  // Next-state and next-register computation for the entry/request FSM.
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    op_s      = op_r;
    next_op_s = next_op_r;
    chain_s   = chain_r;

    if (key_fire_s && is_ac_s) begin
      // AC is only reachable in ready states and acts like a reset.
      state_s   = ST_ENTRY_A;
      a_s       = '0;
      b_s       = '0;
      op_s      = 2'd0;
      next_op_s = 2'd0;
      chain_s   = 1'b0;
    end else begin
      case (state_r)
        ST_ENTRY_A: begin
          if (key_fire_s && is_digit_s) begin
            if (acc_a_fits_s) begin
              a_s = acc_a_s[WIDTH-1:0];
            end else begin
              a_s = a_r;
            end
          end else if (key_fire_s && is_arith_s) begin
            op_s    = key_op_s;
            state_s = ST_OP;
          end else begin
            state_s = ST_ENTRY_A;
          end
        end

        ST_OP: begin
          if (key_fire_s && is_digit_s) begin
            b_s     = digit_s;
            state_s = ST_ENTRY_B;
          end else if (key_fire_s && is_arith_s) begin
            op_s = key_op_s;
          end else begin
            state_s = ST_OP;
          end
        end

        ST_ENTRY_B: begin
          if (key_fire_s && is_digit_s) begin
            if (acc_b_fits_s) begin
              b_s = acc_b_s[WIDTH-1:0];
            end else begin
              b_s = b_r;
            end
          end else if (key_fire_s && is_eq_s) begin
            chain_s = 1'b0;
            state_s = ST_REQ;
          end else if (key_fire_s && is_arith_s) begin
            // Operator pressed instead of EQ: remember it and resume in OP
            // once the pending result lands in a.
            next_op_s = key_op_s;
            chain_s   = 1'b1;
            state_s   = ST_REQ;
          end else begin
            state_s = ST_ENTRY_B;
          end
        end

        ST_REQ: begin
          if (bus.i_alu_ready) begin
            state_s = ST_WAIT_RES;
          end else begin
            state_s = ST_REQ;
          end
        end

        ST_WAIT_RES: begin
          if (bus.i_res_valid && bus.i_res_err) begin
            state_s = ST_ERROR;
          end else if (bus.i_res_valid) begin
            a_s = bus.i_res;
            b_s = '0;
            if (chain_r) begin
              op_s    = next_op_r;
              chain_s = 1'b0;
              state_s = ST_OP;
            end else begin
              state_s = ST_RESULT;
            end
          end else begin
            state_s = ST_WAIT_RES;
          end
        end

        ST_RESULT: begin
          if (key_fire_s && is_digit_s) begin
            a_s     = digit_s;
            state_s = ST_ENTRY_A;
          end else if (key_fire_s && is_arith_s) begin
            op_s    = key_op_s;
            state_s = ST_OP;
          end else begin
            state_s = ST_RESULT;
          end
        end

        ST_ERROR: begin
          // Everything except AC (handled above) is swallowed here.
          state_s = ST_ERROR;
        end

        default: begin
          state_s = ST_ENTRY_A;
        end
      endcase
    end
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_ENTRY_A;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 2'd0;
      next_op_r <= 2'd0;
      chain_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      op_r      <= op_s;
      next_op_r <= next_op_s;
      chain_r   <= chain_s;
    end
  end

  // Output decode; everything is a function of registered state only.
  always_comb begin
    bus.o_key_ready = key_ready_s;
    bus.o_alu_a     = a_r;
    bus.o_alu_b     = b_r;
    bus.o_alu_op    = op_r;
    bus.o_alu_valid = (state_r == ST_REQ);
    bus.o_error     = (state_r == ST_ERROR);
    case (state_r)
      ST_ENTRY_B: bus.o_display = b_r;
      ST_ERROR:   bus.o_display = '0;
      default:    bus.o_display = a_r;
    endcase
  end

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Directed testbench for key_entry_sequencer: keys are pushed through the
// valid/ready port, a scripted ALU answers requests, and every observation
// is compared against hand-computed values.
module tb_key_entry_sequencer;

  localparam int WIDTH = 16;

  localparam logic [4:0] K_AC  = 5'd16;
  localparam logic [4:0] K_ADD = 5'd17;
  localparam logic [4:0] K_SUB = 5'd18;
  localparam logic [4:0] K_MUL = 5'd19;
  localparam logic [4:0] K_DIV = 5'd20;
  localparam logic [4:0] K_EQ  = 5'd21;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  key_entry_sequencer_if #(.WIDTH(WIDTH)) bus ();

  key_entry_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic send_key(input logic [4:0] k);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.o_key_ready) begin
      errors++;
      $display("FAIL key_ready_timeout key=%0d observed ready=%0b required 1", k, bus.o_key_ready);
    end else begin
      bus.i_key       = k;
      bus.i_key_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_key_valid = 1'b0;
      bus.i_key       = 5'd0;
    end
  endtask

  task automatic check_disp(input string name, input logic [WIDTH-1:0] exp);
    #1;
    checks++;
    if (bus.o_display !== exp) begin
      errors++;
      $display("FAIL %s display observed %0d required %0d", name, bus.o_display, exp);
    end
  endtask

  // Wait for a request, check its fields (also during an optional stall),
  // accept it, then return a result strobe.
  task automatic alu_serve(input string name, input logic [WIDTH-1:0] ea,
                           input logic [WIDTH-1:0] eb, input logic [1:0] eop,
                           input int stall, input logic [WIDTH-1:0] res,
                           input logic err);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_alu_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.o_alu_valid) begin
      errors++;
      $display("FAIL %s alu_valid_timeout observed 0 required 1", name);
    end else begin
      for (int c = 0; c <= stall; c++) begin
        checks++;
        if (bus.o_alu_valid !== 1'b1 || bus.o_alu_a !== ea || bus.o_alu_b !== eb ||
            bus.o_alu_op !== eop || bus.o_key_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s req cycle %0d observed v=%0b a=%0d b=%0d op=%0d rdy=%0b required v=1 a=%0d b=%0d op=%0d rdy=0",
                   name, c, bus.o_alu_valid, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op,
                   bus.o_key_ready, ea, eb, eop);
        end
        if (c < stall) @(negedge clk);
      end
      bus.i_alu_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_alu_ready = 1'b0;
      checks++;
      if (bus.o_alu_valid !== 1'b0 || bus.o_key_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s wait_res observed v=%0b rdy=%0b required v=0 rdy=0",
                 name, bus.o_alu_valid, bus.o_key_ready);
      end
      @(negedge clk);
      bus.i_res       = res;
      bus.i_res_err   = err;
      bus.i_res_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_res_valid = 1'b0;
      bus.i_res_err   = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.o_key_ready !== 1'b1 || bus.o_alu_valid !== 1'b0 ||
        bus.o_error !== 1'b0 || bus.o_display !== 16'd0) begin
      errors++;
      $display("FAIL reset observed rdy=%0b v=%0b err=%0b disp=%0d required rdy=1 v=0 err=0 disp=0",
               bus.o_key_ready, bus.o_alu_valid, bus.o_error, bus.o_display);
    end
  endtask

  task automatic test_basic_add;
    send_key(5'd1);
    send_key(5'd2);
    check_disp("basic_a12", 16'd12);
    send_key(K_ADD);
    check_disp("basic_op_shows_a", 16'd12);
    send_key(5'd3);
    check_disp("basic_b3", 16'd3);
    send_key(K_EQ);
    alu_serve("basic_req", 16'd12, 16'd3, 2'b00, 0, 16'd15, 1'b0);
    check_disp("basic_result", 16'd15);
    checks++;
    if (bus.o_key_ready !== 1'b1 || bus.o_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_result_state observed rdy=%0b err=%0b required rdy=1 err=0",
               bus.o_key_ready, bus.o_error);
    end
  endtask

  task automatic test_hold;
    // From RESULT a digit starts a fresh a.
    send_key(5'd4);
    check_disp("hold_a4", 16'd4);
    send_key(K_SUB);
    send_key(5'd1);
    send_key(K_EQ);
    alu_serve("hold_req", 16'd4, 16'd1, 2'b01, 5, 16'd3, 1'b0);
    check_disp("hold_result", 16'd3);
  endtask

  task automatic test_chain;
    send_key(K_AC);
    check_disp("chain_ac", 16'd0);
    send_key(5'd7);
    send_key(K_MUL);
    send_key(5'd6);
    send_key(K_SUB);
    alu_serve("chain_req1", 16'd7, 16'd6, 2'b10, 0, 16'd42, 1'b0);
    check_disp("chain_mid", 16'd42);
    send_key(5'd2);
    check_disp("chain_b2", 16'd2);
    send_key(K_EQ);
    alu_serve("chain_req2", 16'd42, 16'd2, 2'b01, 0, 16'd40, 1'b0);
    check_disp("chain_result", 16'd40);
  endtask

  task automatic test_overflow;
    send_key(K_AC);
    send_key(5'd6);
    send_key(5'd5);
    send_key(5'd5);
    send_key(5'd3);
    check_disp("ovf_6553", 16'd6553);
    send_key(5'd5);
    check_disp("ovf_65535", 16'd65535);
    send_key(5'd6);
    check_disp("ovf_ignored", 16'd65535);
  endtask

  task automatic test_error;
    send_key(K_AC);
    send_key(5'd5);
    send_key(K_DIV);
    send_key(5'd0);
    send_key(K_EQ);
    alu_serve("err_req", 16'd5, 16'd0, 2'b11, 0, 16'd1234, 1'b1);
    #1;
    checks++;
    if (bus.o_error !== 1'b1 || bus.o_display !== 16'd0) begin
      errors++;
      $display("FAIL err_latched observed err=%0b disp=%0d required err=1 disp=0",
               bus.o_error, bus.o_display);
    end
    send_key(5'd3);
    checks++;
    if (bus.o_error !== 1'b1 || bus.o_display !== 16'd0) begin
      errors++;
      $display("FAIL err_key_dropped observed err=%0b disp=%0d required err=1 disp=0",
               bus.o_error, bus.o_display);
    end
    send_key(K_AC);
    checks++;
    if (bus.o_error !== 1'b0 || bus.o_display !== 16'd0 || bus.o_key_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_ac observed err=%0b disp=%0d rdy=%0b required err=0 disp=0 rdy=1",
               bus.o_error, bus.o_display, bus.o_key_ready);
    end
  endtask

  task automatic test_op_replace;
    send_key(K_AC);
    send_key(5'd9);
    send_key(K_ADD);
    send_key(K_SUB);
    send_key(K_EQ);   // ignored in OP
    send_key(5'd4);
    send_key(K_EQ);
    alu_serve("repl_req", 16'd9, 16'd4, 2'b01, 0, 16'd5, 1'b0);
    check_disp("repl_result", 16'd5);
    send_key(5'd8);
    check_disp("repl_new_a", 16'd8);
    send_key(K_ADD);
    send_key(5'd1);
    send_key(K_EQ);
    alu_serve("repl_req2", 16'd8, 16'd1, 2'b00, 0, 16'd9, 1'b0);
    check_disp("repl_result2", 16'd9);
  endtask

  task automatic test_noops;
    send_key(K_AC);
    send_key(5'd2);
    send_key(5'd12);
    send_key(5'd31);
    send_key(K_EQ);
    check_disp("noop_keys", 16'd2);
    // Stray result strobe outside WAIT_RES.
    @(negedge clk);
    bus.i_res       = 16'd77;
    bus.i_res_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_res_valid = 1'b0;
    check_disp("stray_result", 16'd2);
    send_key(5'd1);
    check_disp("noop_then_digit", 16'd21);
  endtask

  task automatic test_reset_mid_request;
    int n;
    send_key(K_ADD);
    send_key(5'd1);
    send_key(K_EQ);
    n = 0;
    @(negedge clk);
    while (!bus.o_alu_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.o_alu_valid !== 1'b0 || bus.o_display !== 16'd0 || bus.o_key_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreq_reset observed v=%0b disp=%0d rdy=%0b required v=0 disp=0 rdy=1",
               bus.o_alu_valid, bus.o_display, bus.o_key_ready);
    end
    @(negedge clk);
    bus.i_res       = 16'd99;
    bus.i_res_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_res_valid = 1'b0;
    check_disp("midreq_late_result", 16'd0);
  endtask

  // Scenario sequence.
  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.i_key       = 5'd0;
    bus.i_key_valid = 1'b0;
    bus.i_alu_ready = 1'b0;
    bus.i_res       = '0;
    bus.i_res_err   = 1'b0;
    bus.i_res_valid = 1'b0;
    test_reset();
    test_basic_add();
    test_hold();
    test_chain();
    test_overflow();
    test_error();
    test_op_replace();
    test_noops();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
